// File: rtl/dp_pkg.sv
// Shared definitions for the pipelined datapath: op encodings, flag bit positions
// and the write-back decode.
package dp_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpAddc = 4'd1,
        OpSub  = 4'd2,
        OpCmp  = 4'd3,
        OpAnd  = 4'd4,
        OpOr   = 4'd5,
        OpXor  = 4'd6,
        OpMov  = 4'd7,
        OpLsh  = 4'd8,
        OpNop  = 4'd15
    } op_e;

    localparam int unsigned NumFlags = 5;
    localparam int unsigned FlagC    = 4;
    localparam int unsigned FlagL    = 3;
    localparam int unsigned FlagF    = 2;
    localparam int unsigned FlagZ    = 1;
    localparam int unsigned FlagN    = 0;

    function automatic logic op_writes(input logic [3:0] op);
        logic wr;
        case (op)
            OpAdd, OpAddc, OpSub, OpAnd, OpOr, OpXor, OpMov, OpLsh: wr = 1'b1;
            default:                                                wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: produces the result, candidate flag values, and a mask of the
// flags the op is allowed to update.
module dp_alu
    import dp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [3:0]          op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    output logic [WIDTH-1:0]    result,
    output logic [NumFlags-1:0] flags,
    output logic [NumFlags-1:0] flag_mask
);

    localparam int unsigned Msb = WIDTH - 1;

    logic             cin_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] shamt;

    assign cin_eff = (op == OpAddc) ? cin : 1'b0;
    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
    // Top bit of the extended difference is the unsigned borrow (a < b).
    assign diff    = {1'b0, a} - {1'b0, b};
    // Negative B means a right shift by its magnitude.
    assign shamt   = b[Msb] ? ({WIDTH{1'b0}} - b) : b;

    always_comb begin
        result    = '0;
        flags     = '0;
        flag_mask = '0;
        case (op)
            OpAdd, OpAddc: begin
                result           = sum[WIDTH-1:0];
                flags[FlagC]     = sum[WIDTH];
                flags[FlagF]     = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
                flag_mask[FlagC] = 1'b1;
                flag_mask[FlagF] = 1'b1;
                flag_mask[FlagZ] = 1'b1;
                flag_mask[FlagN] = 1'b1;
            end
            OpSub: begin
                result           = diff[WIDTH-1:0];
                flags[FlagC]     = diff[WIDTH];
                flags[FlagF]     = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
                flag_mask[FlagC] = 1'b1;
                flag_mask[FlagF] = 1'b1;
                flag_mask[FlagZ] = 1'b1;
                flag_mask[FlagN] = 1'b1;
            end
            OpCmp: begin
                result           = diff[WIDTH-1:0];
                flag_mask[FlagL] = 1'b1;
                flag_mask[FlagZ] = 1'b1;
                flag_mask[FlagN] = 1'b1;
            end
            OpAnd, OpOr, OpXor: begin
                case (op)
                    OpAnd:   result = a & b;
                    OpOr:    result = a | b;
                    default: result = a ^ b;
                endcase
                flag_mask[FlagZ] = 1'b1;
                flag_mask[FlagN] = 1'b1;
            end
            OpMov: result = b;
            OpLsh: begin
                if (shamt >= WIDTH'(WIDTH)) begin
                    result = '0;
                end else if (b[Msb]) begin
                    result = a >> shamt;
                end else begin
                    result = a << shamt;
                end
            end
            default: result = '0;
        endcase

        if (op == OpCmp) begin
            flags[FlagZ] = (a == b);
            flags[FlagL] = diff[WIDTH];
            flags[FlagN] = $signed(a) < $signed(b);
        end else begin
            flags[FlagZ] = (result == '0);
            flags[FlagN] = result[Msb];
        end
    end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage datapath: operand fetch into S1, ALU + result/flag/write-back in S2,
// with S2-to-S1 forwarding so dependent instructions issue back to back.
module pipelined_datapath
    import dp_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    input  logic [3:0]       Op,
    input  logic [IDX_W-1:0] RegA,
    input  logic [IDX_W-1:0] RegB,
    input  logic             UseImm,
    input  logic [WIDTH-1:0] Imm,
    input  logic             Cin,
    output logic [WIDTH-1:0] Result,
    output logic             ResultValid,
    output logic [4:0]       Flags
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic [IDX_W-1:0] s1_rega_q;
    logic [WIDTH-1:0] s1_opa_q;
    logic [WIDTH-1:0] s1_opb_q;
    logic             s1_cin_q;

    logic [WIDTH-1:0]    result_q;
    logic                result_valid_q;
    logic [NumFlags-1:0] flags_q;

    logic [WIDTH-1:0]    alu_result;
    logic [NumFlags-1:0] alu_flags;
    logic [NumFlags-1:0] alu_mask;

    logic             s1_wb;
    logic [WIDTH-1:0] opa_d;
    logic [WIDTH-1:0] opb_d;

    dp_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op        (s1_op_q),
        .a         (s1_opa_q),
        .b         (s1_opb_q),
        .cin       (s1_cin_q),
        .result    (alu_result),
        .flags     (alu_flags),
        .flag_mask (alu_mask)
    );

    // The register file has no bypass; the in-flight S2 result is forwarded instead.
    always_comb begin
        s1_wb = s1_valid_q && op_writes(s1_op_q);
        opa_d = (s1_wb && (s1_rega_q == RegA)) ? alu_result : regs_q[RegA];
        if (UseImm) begin
            opb_d = Imm;
        end else begin
            opb_d = (s1_wb && (s1_rega_q == RegB)) ? alu_result : regs_q[RegB];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            s1_valid_q     <= 1'b0;
            s1_op_q        <= 4'(OpNop);
            s1_rega_q      <= '0;
            s1_opa_q       <= '0;
            s1_opb_q       <= '0;
            s1_cin_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
        end else begin
            s1_valid_q <= InValid;
            if (InValid) begin
                s1_op_q   <= Op;
                s1_rega_q <= RegA;
                s1_opa_q  <= opa_d;
                s1_opb_q  <= opb_d;
                // Carry-in travels with its own instruction.
                s1_cin_q  <= Cin;
            end
            result_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= alu_result;
                flags_q  <= (flags_q & ~alu_mask) | (alu_flags & alu_mask);
                if (s1_wb) begin
                    regs_q[s1_rega_q] <= alu_result;
                end
            end
        end
    end

    assign Result      = result_q;
    assign ResultValid = result_valid_q;
    assign Flags       = flags_q;

endmodule
